// File: rtl/multi_host_bus.sv
// multi_host_bus: shared-bus interconnect from NrHosts hosts to NrDevices
// memory-mapped devices. One grant per cycle. Devices answer one cycle after
// their request. Unmapped addresses get an error response.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   host_*_i / host_*_o   per-host request channel (req/addr/we/be/wdata),
//                         combinational grant, and registered-routing response
//                         (rvalid/rdata/err)
//   device_*_o / _i       per-device request and response channels
//   cfg_device_addr_*     static address map; device d matches when
//                         (addr & mask[d]) == base[d], and the lowest index wins
//
// Build option: define MULTI_HOST_BUS_ROUND_ROBIN_EN for round-robin
// arbitration. Without it, arbitration is fixed priority (lowest host index
// wins).

module multi_host_bus #(
  parameter int NrHosts      = 2,
  parameter int NrDevices    = 3,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic [NrHosts-1:0]      host_req_i,
  output logic [NrHosts-1:0]      host_gnt_o,
  input  logic [AddressWidth-1:0] host_addr_i  [NrHosts],
  input  logic [NrHosts-1:0]      host_we_i,
  input  logic [DataWidth/8-1:0]  host_be_i    [NrHosts],
  input  logic [DataWidth-1:0]    host_wdata_i [NrHosts],
  output logic [NrHosts-1:0]      host_rvalid_o,
  output logic [DataWidth-1:0]    host_rdata_o [NrHosts],
  output logic [NrHosts-1:0]      host_err_o,

  output logic [NrDevices-1:0]    device_req_o,
  output logic [AddressWidth-1:0] device_addr_o  [NrDevices],
  output logic [NrDevices-1:0]    device_we_o,
  output logic [DataWidth/8-1:0]  device_be_o    [NrDevices],
  output logic [DataWidth-1:0]    device_wdata_o [NrDevices],
  input  logic [NrDevices-1:0]    device_rvalid_i,
  input  logic [DataWidth-1:0]    device_rdata_i [NrDevices],
  input  logic [NrDevices-1:0]    device_err_i,

  input  logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices]
);

  localparam int HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
  localparam int BeW      = DataWidth / 8;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // Requests are masked during reset so that no grant or device request leaks
  // out while rst_i is high.
  logic [NrHosts-1:0]  req_eff;
  logic                win_vld;
  logic [HostIdxW-1:0] win_idx;

  assign req_eff = rst_i ? '0 : host_req_i;

`ifdef MULTI_HOST_BUS_ROUND_ROBIN_EN
  logic [HostIdxW-1:0] rr_q, rr_d;
  logic                hi_vld;
  logic [HostIdxW-1:0] hi_idx;
  logic [HostIdxW-1:0] lo_idx;

  // Round-robin as two priority searches. First, find the lowest requester at
  // or above rr_q. If there is none, wrap and take the lowest requester overall.
  always_comb begin
    hi_vld  = 1'b0;
    hi_idx  = '0;
    lo_idx  = '0;
    win_vld = |req_eff;
    for (int h = NrHosts - 1; h >= 0; h--) begin
      if (req_eff[h]) begin
        lo_idx = HostIdxW'(h);
        if (HostIdxW'(h) >= rr_q) begin
          hi_vld = 1'b1;
          hi_idx = HostIdxW'(h);
        end
      end
    end
    win_idx = hi_vld ? hi_idx : lo_idx;

    rr_d = rr_q;
    if (win_vld) begin
      rr_d = (win_idx == HostIdxW'(NrHosts - 1)) ? '0 : win_idx + HostIdxW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  // Fixed priority: the lowest requesting index wins.
  always_comb begin
    win_vld = |req_eff;
    win_idx = '0;
    for (int h = NrHosts - 1; h >= 0; h--) begin
      if (req_eff[h]) win_idx = HostIdxW'(h);
    end
  end
`endif

  // Select the winner's request fields.
  logic [AddressWidth-1:0] win_addr;
  logic                    win_we;
  logic [BeW-1:0]          win_be;
  logic [DataWidth-1:0]    win_wdata;

  always_comb begin
    win_addr  = '0;
    win_we    = 1'b0;
    win_be    = '0;
    win_wdata = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (win_idx == HostIdxW'(h)) begin
        win_addr  = host_addr_i[h];
        win_we    = host_we_i[h];
        win_be    = host_be_i[h];
        win_wdata = host_wdata_i[h];
      end
    end
  end

  always_comb begin
    host_gnt_o = '0;
    for (int h = 0; h < NrHosts; h++) begin
      host_gnt_o[h] = win_vld && (win_idx == HostIdxW'(h));
    end
  end

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  // The loop runs from the highest index down, so the lowest matching index
  // is written last and wins when the map overlaps.
  logic               dec_hit;
  logic [DevIdxW-1:0] dec_idx;

  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((win_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
        dec_hit = 1'b1;
        dec_idx = DevIdxW'(d);
      end
    end
  end

  // Every device sees the winner's fields. Only the decoded device gets req.
  always_comb begin
    device_req_o = '0;
    device_we_o  = '0;
    for (int d = 0; d < NrDevices; d++) begin
      device_req_o[d]   = win_vld && dec_hit && (dec_idx == DevIdxW'(d));
      device_addr_o[d]  = win_addr;
      device_we_o[d]    = win_we;
      device_be_o[d]    = win_be;
      device_wdata_o[d] = win_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------------
  logic                rsp_valid_q, rsp_valid_d;
  logic [HostIdxW-1:0] rsp_host_q,  rsp_host_d;
  logic [DevIdxW-1:0]  rsp_dev_q,   rsp_dev_d;
  logic                rsp_miss_q,  rsp_miss_d;

  assign rsp_valid_d = win_vld;
  assign rsp_host_d  = win_idx;
  assign rsp_dev_d   = dec_idx;
  assign rsp_miss_d  = !dec_hit;

  // An asynchronous reset drops any response in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_host_q  <= '0;
      rsp_dev_q   <= '0;
      rsp_miss_q  <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_host_q  <= rsp_host_d;
      rsp_dev_q   <= rsp_dev_d;
      rsp_miss_q  <= rsp_miss_d;
    end
  end

  logic [DataWidth-1:0] sel_rdata;
  logic                 sel_err;
  logic                 sel_rvalid;

  always_comb begin
    sel_rdata  = '0;
    sel_err    = 1'b0;
    sel_rvalid = 1'b0;
    for (int d = 0; d < NrDevices; d++) begin
      if (rsp_dev_q == DevIdxW'(d)) begin
        sel_rdata  = device_rdata_i[d];
        sel_err    = device_err_i[d];
        sel_rvalid = device_rvalid_i[d];
      end
    end
  end

  // Only the addressed host sees a response. All other hosts see zeros.
  // A decode miss answers with rdata 0 and err 1.
  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    for (int h = 0; h < NrHosts; h++) begin
      host_rdata_o[h] = '0;
      if (rsp_valid_q && (rsp_host_q == HostIdxW'(h))) begin
        host_rvalid_o[h] = 1'b1;
        host_err_o[h]    = rsp_miss_q | sel_err;
        host_rdata_o[h]  = rsp_miss_q ? '0 : sel_rdata;
      end
    end
  end

  // The addressed device must answer in the cycle right after its request.
  // The response path does not use rvalid, so this is only checked here.
  a_dev_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
    (rsp_valid_q && !rsp_miss_q) |-> sel_rvalid);

endmodule
